ftdi_rx_frame_parser: RTL and testbench
=======================================

Name: ftdi_rx_frame_parser

Overview:
Downstream consumer of the USB receive path. It takes the receive AXI4-Stream that leaves the RX width converter in the rx_clk domain and splits each tlast-delimited packet into a header word and a payload. It validates the sync word and the declared length, forwards the payload with its command code in tuser, drops malformed frames, and keeps saturating status counters for the register bank.

Parameters:
DATA_BYTES, 4, input/output tdata width in bytes; legal range 4-64; header fields sit in bits [31:0].
SYNC_WORD, 16'hA55A, required value of header bits [31:16].
CNT_WIDTH, 16, width of each status counter.

Ports:
rx_clk  in  1  block clock, the RX user clock.
rst_rxclk  in  1  asynchronous active-high reset.
s_axis_tvalid  in  1  input stream valid.
s_axis_tready  out  1  input stream ready.
s_axis_tdata  in  DATA_BYTES*8  input data.
s_axis_tkeep  in  DATA_BYTES  input byte enables.
s_axis_tlast  in  1  end of USB packet.
m_axis_tvalid  out  1  payload valid.
m_axis_tready  in  1  payload ready.
m_axis_tdata  out  DATA_BYTES*8  payload data.
m_axis_tkeep  out  DATA_BYTES  payload byte enables.
m_axis_tlast  out  1  last payload word of the frame.
m_axis_tuser  out  8  command code of the current frame.
frame_done  out  1  one-cycle pulse when a frame closes.
frame_status  out  2  status of the closing frame: 0 ok, 1 sync error, 2 short (early tlast), 3 long (missing tlast); valid with frame_done.
cnt_frames_ok  out  CNT_WIDTH  saturating count of good frames.
cnt_err_sync  out  CNT_WIDTH  saturating count of sync errors.
cnt_err_len  out  CNT_WIDTH  saturating count of short and long frames combined.

Behaviour:
Interface (already decided):
- One clock, rx_clk.
- Reset rst_rxclk is asynchronous and active-high.
- In reset every output is 0, including all counters; state is HDR and the word counter is 0.

Header word, low 32 bits:
- [31:16] sync.
- [15:8] cmd.
- [7:0] LEN, the payload word count, 0-255.

States:
- HDR: s_axis_tready=1. On a beat:
  - sync!=SYNC_WORD: if tlast=0 go to DROP with pending status 1; if tlast=1 close with status 1.
  - sync ok, LEN=0, tlast=1: close with status 0; no payload is emitted.
  - sync ok, LEN=0, tlast=0: go to DROP with pending status 3.
  - sync ok, LEN>0, tlast=1: close with status 2.
  - sync ok, LEN>0, tlast=0: latch cmd and LEN, clear the word counter, go to PAY.
- PAY: s_axis_tready = !m_axis_tvalid || m_axis_tready. One output register stage, so latency is 1 cycle from an accepted input beat to m_axis_tvalid. On each accepted beat, load tdata/tkeep into the output register and set tuser=cmd; the counter increments. At beat number LEN, or on an earlier beat:
  - counter+1==LEN and tlast=1: m_axis_tlast=1, close with status 0, go to HDR.
  - counter+1<LEN and tlast=1: m_axis_tlast=1 (the frame is truncated downstream), close with status 2, go to HDR.
  - counter+1==LEN and tlast=0: m_axis_tlast=1, go to DROP with pending status 3.
- DROP: s_axis_tready=1 and beats are discarded. On tlast, close with the pending status and go to HDR.

Close rules:
- frame_done and frame_status are registered, asserted the cycle after the closing input beat.
- Exactly one counter increments per close. Counters saturate at all-ones.
- A payload word held in the output register drains while the FSM is in HDR or DROP; the output register is independent of the FSM.
- In PAY, m_axis_tvalid stays high with stable data until m_axis_tready is seen (AXIS rules).
- Reset mid-frame discards the frame with no frame_done; the first beat after reset is treated as a header.
- s_axis_tkeep on the header word is ignored.

Decomposition:
Shared package ftdi_frame_pkg holds:
- SYNC_WORD default.
- Status codes ST_OK, ST_SYNC, ST_SHORT, ST_LONG.
- Header field bit positions.
- The state enum HDR/PAY/DROP.

One natural sub-module, axis_reg_slice: a one-deep AXIS output register carrying tdata/tkeep/tlast/tuser.

Test Plan:
- Header A55A_05_03 followed by 3 words, tlast on word 3, m_axis_tready=1 → 3 output beats with tuser=8'h05 and tlast on beat 3; frame_done pulse with status 0; cnt_frames_ok=1.
- Header 1234_01_02 followed by 2 words with tlast → no output beats; status 1; cnt_err_sync=1; the next valid frame passes unchanged.
- Header LEN=4 with tlast on payload word 2 → 2 beats out, the second with tlast; status 2; cnt_err_len=1.
- Header LEN=2 followed by 5 words with tlast on word 5 → 2 beats out with tlast on beat 2; words 3-5 dropped; status 3 on word 5.
- Header LEN=0 with tlast → no payload; status 0. Back-to-back frames with random m_axis_tready backpressure → no loss or duplication and tdata stable while stalled. Counter preloaded to 16'hFFFF stays at 16'hFFFF after a further close.
- rst_rxclk pulsed in the middle of PAY → all outputs 0 immediately (asynchronously); no frame_done; the next header is accepted normally.

Source files
------------

// File: rtl/ftdi_frame_pkg.sv
// Shared definitions for the RX frame parser: the default sync word, the
// frame status codes, the header field positions and the parser states.
package ftdi_frame_pkg;

    localparam logic [15:0] SYNC_WORD_DEF = 16'hA55A;

    // Header layout inside the low 32 bits of the first beat of a packet
    localparam int HDR_SYNC_MSB = 31;
    localparam int HDR_SYNC_LSB = 16;
    localparam int HDR_CMD_MSB  = 15;
    localparam int HDR_CMD_LSB  = 8;
    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 0;

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_SYNC  = 2'd1,
        ST_SHORT = 2'd2,
        ST_LONG  = 2'd3
    } frame_status_t;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        PAY  = 2'd1,
        DROP = 2'd2
    } parse_state_t;

endpackage

// File: rtl/ftdi_rx_frame_parser_if.sv
// AXI4-Stream bundle used for both the raw receive stream and the payload
// stream; tuser carries the command code on the payload side.
interface ftdi_rx_frame_parser_if #(
    parameter int DATA_BYTES = 4
) ();
    logic                    tvalid;
    logic                    tready;
    logic [DATA_BYTES*8-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic                    tlast;
    logic [7:0]              tuser;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/axis_reg_slice.sv
// One-deep AXIS output register. Holds a word stable until the consumer
// takes it and accepts a new one in the same cycle the old one leaves.
module axis_reg_slice #(
    parameter int DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_BYTES*8-1:0] in_data,
    input  logic [DATA_BYTES-1:0]   in_keep,
    input  logic                    in_last,
    input  logic [7:0]              in_user,
    ftdi_rx_frame_parser_if.master  m_axis
);

    logic                    vld_p1;
    logic [DATA_BYTES*8-1:0] data_p1;
    logic [DATA_BYTES-1:0]   keep_p1;
    logic                    last_p1;
    logic [7:0]              user_p1;

    assign in_ready = !vld_p1 || m_axis.tready;

    // Output register stage: load on a free slot, otherwise hold for the consumer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            keep_p1 <= '0;
            last_p1 <= 1'b0;
            user_p1 <= '0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                data_p1 <= in_data;
                keep_p1 <= in_keep;
                last_p1 <= in_last;
                user_p1 <= in_user;
            end
        end
    end

    assign m_axis.tvalid = vld_p1;
    assign m_axis.tdata  = data_p1;
    assign m_axis.tkeep  = keep_p1;
    assign m_axis.tlast  = last_p1;
    assign m_axis.tuser  = user_p1;

endmodule

// File: rtl/ftdi_rx_frame_parser.sv
// Splits each tlast-delimited USB packet into a header and a payload,
// checks sync and length, forwards the payload tagged with its command code,
// discards malformed frames and keeps saturating status counters.
module ftdi_rx_frame_parser
    import ftdi_frame_pkg::*;
#(
    parameter int          DATA_BYTES = 4,
    parameter logic [15:0] SYNC_WORD  = SYNC_WORD_DEF,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                   rx_clk,
    input  logic                   rst_rxclk,
    ftdi_rx_frame_parser_if.slave  s_axis,
    ftdi_rx_frame_parser_if.master m_axis,
    output logic                   frame_done,
    output logic [1:0]             frame_status,
    output logic [CNT_WIDTH-1:0]   cnt_frames_ok,
    output logic [CNT_WIDTH-1:0]   cnt_err_sync,
    output logic [CNT_WIDTH-1:0]   cnt_err_len
);

    // Counters stick at all-ones instead of wrapping
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    parse_state_t  state_q;
    frame_status_t pend_q;
    logic [7:0]    cnt_q;
    logic [7:0]    len_q;
    logic [7:0]    cmd_q;

    logic [15:0]   hdr_sync;
    logic [7:0]    hdr_cmd;
    logic [7:0]    hdr_len;
    logic          sync_ok;
    logic          beat;
    logic          last_word;
    logic          slice_ready;
    logic          pay_valid;
    logic          pay_last;
    logic          close_en;
    frame_status_t close_code;

    // The input tuser has no meaning on the receive side
    logic unused_s_tuser;
    assign unused_s_tuser = ^s_axis.tuser;

    assign hdr_sync = s_axis.tdata[HDR_SYNC_MSB:HDR_SYNC_LSB];
    assign hdr_cmd  = s_axis.tdata[HDR_CMD_MSB:HDR_CMD_LSB];
    assign hdr_len  = s_axis.tdata[HDR_LEN_MSB:HDR_LEN_LSB];
    assign sync_ok  = (hdr_sync == SYNC_WORD);

    // Only PAY waits on the output register; HDR and DROP always sink beats.
    // Ready is held low while reset is asserted so every output reads 0.
    assign s_axis.tready = !rst_rxclk && ((state_q == PAY) ? slice_ready : 1'b1);
    assign beat          = s_axis.tvalid && s_axis.tready;
    assign last_word     = ({1'b0, cnt_q} + 9'd1) == {1'b0, len_q};
    assign pay_valid     = (state_q == PAY) && beat;
    assign pay_last      = s_axis.tlast || last_word;

    // Decide whether the current beat closes a frame and with which status
    always_comb begin
        close_en   = 1'b0;
        close_code = ST_OK;
        if (beat && s_axis.tlast) begin
            close_en = 1'b1;
            case (state_q)
                HDR: begin
                    if (!sync_ok)            close_code = ST_SYNC;
                    else if (hdr_len == 8'd0) close_code = ST_OK;
                    else                      close_code = ST_SHORT;
                end
                PAY:     close_code = last_word ? ST_OK : ST_SHORT;
                DROP:    close_code = pend_q;
                default: close_code = ST_OK;
            endcase
        end
    end

    // Parser FSM with registered close pulse and status counters
    always_ff @(posedge rx_clk or posedge rst_rxclk) begin
        if (rst_rxclk) begin
            state_q       <= HDR;
            pend_q        <= ST_OK;
            cnt_q         <= '0;
            len_q         <= '0;
            cmd_q         <= '0;
            frame_done    <= 1'b0;
            frame_status  <= '0;
            cnt_frames_ok <= '0;
            cnt_err_sync  <= '0;
            cnt_err_len   <= '0;
        end else begin
            frame_done <= close_en;
            if (close_en) begin
                frame_status <= close_code;
                case (close_code)
                    ST_OK:   cnt_frames_ok <= sat_inc(cnt_frames_ok);
                    ST_SYNC: cnt_err_sync  <= sat_inc(cnt_err_sync);
                    default: cnt_err_len   <= sat_inc(cnt_err_len);
                endcase
            end

            case (state_q)
                HDR: begin
                    if (beat && !s_axis.tlast) begin
                        if (!sync_ok) begin
                            state_q <= DROP;
                            pend_q  <= ST_SYNC;
                        end else if (hdr_len == 8'd0) begin
                            state_q <= DROP;
                            pend_q  <= ST_LONG;
                        end else begin
                            state_q <= PAY;
                            cmd_q   <= hdr_cmd;
                            len_q   <= hdr_len;
                            cnt_q   <= '0;
                        end
                    end
                end
                PAY: begin
                    if (beat) begin
                        if (s_axis.tlast) begin
                            state_q <= HDR;
                        end else if (last_word) begin
                            state_q <= DROP;
                            pend_q  <= ST_LONG;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                DROP: begin
                    if (beat && s_axis.tlast) state_q <= HDR;
                end
                default: state_q <= HDR;
            endcase
        end
    end

    axis_reg_slice #(
        .DATA_BYTES (DATA_BYTES)
    ) u_out_slice (
        .clk      (rx_clk),
        .rst      (rst_rxclk),
        .in_valid (pay_valid),
        .in_ready (slice_ready),
        .in_data  (s_axis.tdata),
        .in_keep  (s_axis.tkeep),
        .in_last  (pay_last),
        .in_user  (cmd_q),
        .m_axis   (m_axis)
    );

endmodule

// File: tb/tb_ftdi_rx_frame_parser.sv
// Directed bench for the RX frame parser: frames of every status class,
// backpressure with hold checks, counter saturation and reset mid-payload.
module tb_ftdi_rx_frame_parser;
    import ftdi_frame_pkg::*;

    localparam int DB = 4;
    localparam int CW = 2;   // narrow counters so saturation is reachable

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ftdi_rx_frame_parser_if #(.DATA_BYTES(DB)) s_if ();
    ftdi_rx_frame_parser_if #(.DATA_BYTES(DB)) m_if ();

    logic          frame_done;
    logic [1:0]    frame_status;
    logic [CW-1:0] c_ok, c_sync, c_len;

    ftdi_rx_frame_parser #(
        .DATA_BYTES (DB),
        .SYNC_WORD  (16'hA55A),
        .CNT_WIDTH  (CW)
    ) dut (
        .rx_clk        (clk),
        .rst_rxclk     (rst),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .frame_done    (frame_done),
        .frame_status  (frame_status),
        .cnt_frames_ok (c_ok),
        .cnt_err_sync  (c_sync),
        .cnt_err_len   (c_len)
    );

    int n_checks = 0;
    int n_errors = 0;

    // beat word layout: {keep[3:0], user[7:0], last, data[31:0]}
    logic [44:0] got_q[$];
    logic [44:0] exp_q[$];
    logic [1:0]  got_st[$];
    logic [1:0]  exp_st[$];
    int          m_ok, m_sync, m_len;
    bit          bp_en = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat3(input int v);
        return (v >= 3) ? 3 : v + 1;
    endfunction

    function automatic logic [31:0] pay_word(input logic [7:0] fid, input int i);
        return {8'hC0, fid, 8'h5A, 8'(i)};
    endfunction

    // Consumer ready: always high, or random when backpressure is enabled
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(negedge clk);
            m_if.tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: records handshakes and closes, checks hold while stalled
    initial begin
        logic        stalled;
        logic [44:0] held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check_val("stall_valid", m_if.tvalid, 1);
                    check_val("stall_data", {m_if.tkeep, m_if.tuser, m_if.tlast, m_if.tdata}, held);
                end
                if (m_if.tvalid && m_if.tready) begin
                    got_q.push_back({m_if.tkeep, m_if.tuser, m_if.tlast, m_if.tdata});
                    stalled = 1'b0;
                end else if (m_if.tvalid) begin
                    stalled = 1'b1;
                    held    = {m_if.tkeep, m_if.tuser, m_if.tlast, m_if.tdata};
                end else begin
                    stalled = 1'b0;
                end
                if (frame_done) got_st.push_back(frame_status);
            end
        end
    end

    // Drive one input beat starting at a falling edge; returns after acceptance
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic last);
        logic acc;
        acc = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = last;
        for (int n = 0; n < 200 && !acc; n++) begin
            #1;
            acc = s_if.tready;
            @(negedge clk);
        end
        s_if.tvalid = 1'b0;
        if (!acc) check_val("handshake_timeout", 0, 1);
    endtask

    // Expected behaviour of one frame: header then nwords payload beats, tlast on the final beat
    task automatic expect_frame(input logic [15:0] sync, input logic [7:0] cmd,
                                input int len, input int nwords, input logic [7:0] fid);
        int       n_out;
        logic [1:0] st;
        logic [3:0] k;
        if (sync != 16'hA55A)  begin n_out = 0;      st = 2'd1; end
        else if (len == 0)     begin n_out = 0;      st = (nwords == 0) ? 2'd0 : 2'd3; end
        else if (nwords == 0)  begin n_out = 0;      st = 2'd2; end
        else if (nwords < len) begin n_out = nwords; st = 2'd2; end
        else if (nwords == len) begin n_out = len;   st = 2'd0; end
        else                   begin n_out = len;    st = 2'd3; end
        for (int i = 1; i <= n_out; i++) begin
            k = (i == nwords) ? 4'b0011 : 4'b1111;
            exp_q.push_back({k, cmd, 1'(i == n_out), pay_word(fid, i)});
        end
        exp_st.push_back(st);
        case (st)
            2'd0:    m_ok   = sat3(m_ok);
            2'd1:    m_sync = sat3(m_sync);
            default: m_len  = sat3(m_len);
        endcase
    endtask

    task automatic send_frame(input logic [15:0] sync, input logic [7:0] cmd,
                              input int len, input int nwords, input logic [7:0] fid);
        send_beat({sync, cmd, 8'(len)}, 4'h0, nwords == 0);
        for (int i = 1; i <= nwords; i++)
            send_beat(pay_word(fid, i), (i == nwords) ? 4'b0011 : 4'b1111, i == nwords);
    endtask

    task automatic do_frame(input logic [15:0] sync, input logic [7:0] cmd,
                            input int len, input int nwords, input logic [7:0] fid);
        expect_frame(sync, cmd, len, nwords, fid);
        send_frame(sync, cmd, len, nwords, fid);
    endtask

    // Wait for the outputs to drain, then compare everything recorded against the model
    task automatic verify(input string tag);
        int n;
        for (int c = 0; c < 300; c++) begin
            if (got_q.size() >= exp_q.size() && got_st.size() >= exp_st.size()) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check_val({tag, "_nbeats"}, got_q.size(), exp_q.size());
        check_val({tag, "_ncloses"}, got_st.size(), exp_st.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_val({tag, "_beat"}, got_q[i], exp_q[i]);
        n = (got_st.size() < exp_st.size()) ? got_st.size() : exp_st.size();
        for (int i = 0; i < n; i++) check_val({tag, "_status"}, got_st[i], exp_st[i]);
        check_val({tag, "_cnt_ok"}, c_ok, m_ok);
        check_val({tag, "_cnt_sync"}, c_sync, m_sync);
        check_val({tag, "_cnt_len"}, c_len, m_len);
        got_q.delete(); exp_q.delete(); got_st.delete(); exp_st.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = '0;
        m_ok = 0; m_sync = 0; m_len = 0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_s_tready", s_if.tready, 0);
        check_val("rst_m_tvalid", m_if.tvalid, 0);
        check_val("rst_m_tdata", m_if.tdata, 0);
        check_val("rst_frame_done", frame_done, 0);
        check_val("rst_counters", {c_ok, c_sync, c_len}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("idle_s_tready", s_if.tready, 1);
        @(negedge clk);

        // Good frame, LEN 3
        do_frame(16'hA55A, 8'h05, 3, 3, 8'h01);
        verify("good");
        check_val("good_cnt_ok_lit", c_ok, 1);

        // Sync error, then a good frame must pass untouched
        do_frame(16'h1234, 8'h01, 2, 2, 8'h02);
        do_frame(16'hA55A, 8'h07, 2, 2, 8'h03);
        verify("sync");
        check_val("sync_cnt_lit", c_sync, 1);

        // Short frame: LEN 4, tlast on payload word 2
        do_frame(16'hA55A, 8'h09, 4, 2, 8'h04);
        verify("short");

        // Long frame: LEN 2, five payload words
        do_frame(16'hA55A, 8'h0B, 2, 5, 8'h05);
        verify("long");

        // Header-only cases
        do_frame(16'hA55A, 8'h0C, 0, 0, 8'h06);
        do_frame(16'hA55A, 8'h0D, 0, 1, 8'h07);
        do_frame(16'hA55A, 8'h0E, 3, 0, 8'h08);
        do_frame(16'hBEEF, 8'h0F, 1, 0, 8'h09);
        verify("hdr_only");

        // Back-to-back frames under random backpressure
        bp_en = 1'b1;
        for (int f = 0; f < 6; f++)
            do_frame(16'hA55A, 8'(8'h20 + f), 1 + f % 3, 1 + f % 3, 8'(8'h10 + f));
        do_frame(16'hA55A, 8'h28, 2, 3, 8'h18);
        do_frame(16'hA55A, 8'h29, 3, 1, 8'h19);
        verify("bp");
        bp_en = 1'b0;
        repeat (2) @(negedge clk);
        check_val("sat_ok", c_ok, 3);
        check_val("sat_len", c_len, 3);

        // Reset in the middle of a payload
        send_beat({16'hA55A, 8'h30, 8'd4}, 4'h0, 1'b0);
        send_beat(pay_word(8'h30, 1), 4'hF, 1'b0);
        send_beat(pay_word(8'h30, 2), 4'hF, 1'b0);
        check_val("pre_rst_m_tvalid", m_if.tvalid, 1);
        #3 rst = 1'b1;
        #1;
        check_val("async_m_tvalid", m_if.tvalid, 0);
        check_val("async_m_tdata", m_if.tdata, 0);
        check_val("async_m_side", {m_if.tlast, m_if.tuser, m_if.tkeep}, 0);
        check_val("async_s_tready", s_if.tready, 0);
        check_val("async_done", {frame_done, frame_status}, 0);
        check_val("async_counters", {c_ok, c_sync, c_len}, 0);
        got_q.delete(); exp_q.delete(); got_st.delete(); exp_st.delete();
        m_ok = 0; m_sync = 0; m_len = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_frame(16'hA55A, 8'h31, 2, 2, 8'h40);
        verify("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
